// File: rtl/clock_pkg.sv
// Shared definitions for the clock set controller, display mux and counters.
package clock_pkg;

  // Controller states: view/minutes/hours for the time bank and the alarm bank.
  typedef enum logic [2:0] {
    T_VIEW = 3'd0,
    T_MIN  = 3'd1,
    T_HR   = 3'd2,
    A_VIEW = 3'd3,
    A_MIN  = 3'd4,
    A_HR   = 3'd5
  } clk_state_e;

  // Field codes driven on the field output.
  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_MIN  = 2'b01;
  localparam logic [1:0] FLD_HR   = 2'b10;

  // High in the states where a field is being edited.
  function automatic logic is_set(input clk_state_e s);
    return (s inside {T_MIN, T_HR, A_MIN, A_HR});
  endfunction

  // High in any alarm-bank state.
  function automatic logic is_alm(input clk_state_e s);
    return (s inside {A_VIEW, A_MIN, A_HR});
  endfunction

  // Field code shown for a given state.
  function automatic logic [1:0] field_of(input clk_state_e s);
    case (s)
      T_MIN, A_MIN: return FLD_MIN;
      T_HR,  A_HR:  return FLD_HR;
      default:      return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat for the increment button.
// pulse_o = press | repeat; the repeat counter only runs while hold_en_i is high.
module btn_repeat #(
  parameter int REPEAT_DELAY = 5,
  parameter int REPEAT_RATE  = 2,
  parameter int TW           = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic lvl_i,
  input  logic hold_en_i,
  output logic pulse_o
);

  logic          prev_q;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;
  logic          press;
  logic          rep;

  // Edge detect and repeat-counter next state; a fresh press restarts the hold count,
  // and after the first repeat the counter reloads so strobes follow every REPEAT_RATE ticks.
  always_comb begin
    press = lvl_i & ~prev_q;
    rep   = 1'b0;
    cnt_d = cnt_q;
    if (!lvl_i || !hold_en_i || press) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == TW'(REPEAT_DELAY - 1)) begin
        rep   = 1'b1;
        cnt_d = TW'(REPEAT_DELAY - REPEAT_RATE);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  // Level history and hold counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= lvl_i;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse_o = press | rep;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/field sequencer for the 7-segment clock: turns MODE/CMODE/Ch levels into
// registered increment strobes for the time or alarm bank, plus blink and seconds-clear.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 5,
  parameter int REPEAT_RATE  = 2,
  parameter int TIMEOUT      = 100,
  parameter int BLINK_HALF   = 5,
  parameter int TW           = 8
) (
  input  logic       Cp,
  input  logic       reset,
  input  logic       tick,
  input  logic       MODE,
  input  logic       CMODE,
  input  logic       Ch,
  output logic       inc_min,
  output logic       inc_hr,
  output logic       bank_alm,
  output logic [1:0] field,
  output logic       blink,
  output logic       sec_clr,
  output logic       setting
);

  clk_state_e    state_q, state_d;
  logic          mode_prev_q, cmode_prev_q;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [TW-1:0] bl_cnt_q, bl_cnt_d;
  logic          blink_q, blink_d;
  logic          inc_min_q, inc_hr_q, bank_alm_q, sec_clr_q, setting_q;
  logic [1:0]    field_q;

  logic mode_press, cmode_press, set_now, hold_en, ch_pulse, inc_fire, to_hit, state_chg;

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .TW          (TW)
  ) u_ch_rep (
    .clk_i    (Cp),
    .rst_ni   (reset),
    .tick_i   (tick),
    .lvl_i    (Ch),
    .hold_en_i(hold_en),
    .pulse_o  (ch_pulse)
  );

  // Press decode, priority (MODE > CMODE > Ch), timeout detection and next state.
  always_comb begin
    mode_press  = MODE & ~mode_prev_q;
    cmode_press = CMODE & ~cmode_prev_q;
    set_now     = is_set(state_q);
    hold_en     = set_now & ~mode_press & ~cmode_press;
    inc_fire    = hold_en & ch_pulse;
    to_hit      = set_now & tick & ~mode_press & ~cmode_press & ~inc_fire &
                  (to_cnt_q == TW'(TIMEOUT - 1));
    state_d = state_q;
    if (mode_press) begin
      state_d = is_alm(state_q) ? T_VIEW : A_VIEW;
    end else if (cmode_press) begin
      case (state_q)
        T_VIEW:  state_d = T_MIN;
        T_MIN:   state_d = T_HR;
        T_HR:    state_d = T_VIEW;
        A_VIEW:  state_d = A_MIN;
        A_MIN:   state_d = A_HR;
        default: state_d = A_VIEW;
      endcase
    end else if (to_hit) begin
      state_d = is_alm(state_q) ? A_VIEW : T_VIEW;
    end
    state_chg = (state_d != state_q);
  end

  // Inactivity and blink counters; a press or state change clears them ahead of any tick.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!set_now || state_chg || inc_fire) begin
      to_cnt_d = '0;
    end else if (tick && to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    bl_cnt_d = bl_cnt_q;
    blink_d  = blink_q;
    if (!is_set(state_d) || state_chg) begin
      bl_cnt_d = '0;
      blink_d  = 1'b0;
    end else if (tick) begin
      if (bl_cnt_q == TW'(BLINK_HALF - 1)) begin
        bl_cnt_d = '0;
        blink_d  = ~blink_q;
      end else begin
        bl_cnt_d = bl_cnt_q + TW'(1);
      end
    end
  end

  // Button history and counter registers.
  always_ff @(posedge Cp or negedge reset) begin
    if (!reset) begin
      mode_prev_q  <= 1'b0;
      cmode_prev_q <= 1'b0;
      to_cnt_q     <= '0;
      bl_cnt_q     <= '0;
      blink_q      <= 1'b0;
    end else begin
      mode_prev_q  <= MODE;
      cmode_prev_q <= CMODE;
      to_cnt_q     <= to_cnt_d;
      bl_cnt_q     <= bl_cnt_d;
      blink_q      <= blink_d;
    end
  end

  // FSM state and registered outputs decoded from the next state.
  always_ff @(posedge Cp or negedge reset) begin
    if (!reset) begin
      state_q    <= T_VIEW;
      bank_alm_q <= 1'b0;
      field_q    <= FLD_NONE;
      setting_q  <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_hr_q   <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_alm_q <= is_alm(state_d);
      field_q    <= field_of(state_d);
      setting_q  <= is_set(state_d);
      inc_min_q  <= inc_fire & (field_of(state_q) == FLD_MIN);
      inc_hr_q   <= inc_fire & (field_of(state_q) == FLD_HR);
      sec_clr_q  <= cmode_press & ~mode_press & (state_q == T_VIEW);
    end
  end

  assign inc_min  = inc_min_q;
  assign inc_hr   = inc_hr_q;
  assign bank_alm = bank_alm_q;
  assign field    = field_q;
  assign blink    = blink_q;
  assign sec_clr  = sec_clr_q;
  assign setting  = setting_q;

endmodule
